// File: rtl/rms_sqrt_scheduler_if.sv
// Request/response bundle between the RMS channels, the shared sqrt
// scheduler and the result consumer.
interface rms_sqrt_scheduler_if #(
    parameter int NCH = 4,
    parameter int W   = 16
);
    logic [NCH-1:0]   req_valid;
    logic [NCH*W-1:0] req_radicand;
    logic [NCH-1:0]   req_ready;
    logic             resp_valid;
    logic [2:0]       resp_ch;
    logic [W-1:0]     resp_root;
    logic             resp_ready;

    // Requesters and consumer drive requests and accept results.
    modport master (
        output req_valid, req_radicand, resp_ready,
        input  req_ready, resp_valid, resp_ch, resp_root
    );

    // The scheduler grants requests and presents results.
    modport slave (
        input  req_valid, req_radicand, resp_ready,
        output req_ready, resp_valid, resp_ch, resp_root
    );
endinterface

// File: rtl/rms_sqrt_scheduler.sv
// Shared restoring integer square-root engine for NCH requesting channels.
// A round-robin arbiter picks one channel in IDLE, the datapath produces one
// root bit per cycle for W/2 cycles, and the result is held with its channel
// tag until the consumer accepts it.
module rms_sqrt_scheduler #(
    parameter int NCH = 4,
    parameter int W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    rms_sqrt_scheduler_if.slave  bus,
    output logic                 busy
);
    localparam int HW = W / 2;
    localparam int RW = HW + 2;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_CNT = CW'(HW - 1);
    localparam logic [3:0]    NCH_L    = 4'(NCH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [2:0]      ptr_r;
    logic [CW-1:0]   cnt_r;
    logic [W-1:0]    x_r;
    logic [RW-1:0]   rem_r;
    logic [HW-1:0]   root_r;
    logic            resp_valid_r;
    logic [2:0]      resp_ch_r;
    logic [W-1:0]    resp_root_r;
    logic            busy_r;

    logic            grant_hit_s;
    logic [2:0]      grant_idx_s;
    logic [NCH-1:0]  grant_s;
    logic [W-1:0]    grant_rad_s;
    logic [RW-1:0]   trial_s;
    logic [RW-1:0]   cmp_s;
    logic [RW-1:0]   rem_next_s;
    logic [HW-1:0]   root_next_s;

    // Channel index base+off wrapped modulo NCH; both operands are below NCH.
    function automatic logic [2:0] wrap_idx(input logic [2:0] base, input logic [2:0] off);
        logic [3:0] sum_v;
        sum_v = {1'b0, base} + {1'b0, off};
        if (sum_v >= NCH_L) begin
            sum_v = sum_v - NCH_L;
        end else begin
            sum_v = sum_v;
        end
        return sum_v[2:0];
    endfunction

    // Round-robin search from ptr; lowest distance wins, so scan distances high to low.
    always_comb begin
        grant_hit_s = 1'b0;
        grant_idx_s = 3'd0;
        grant_s     = '0;
        grant_rad_s = '0;
        if ((state_r == IDLE) && !rst) begin
            for (int i = NCH - 1; i >= 0; i--) begin
                for (int c = 0; c < NCH; c++) begin
                    if (bus.req_valid[c] && (wrap_idx(ptr_r, 3'(i)) == 3'(c))) begin
                        grant_hit_s = 1'b1;
                        grant_idx_s = 3'(c);
                    end else begin
                        grant_hit_s = grant_hit_s;
                    end
                end
            end
            for (int c = 0; c < NCH; c++) begin
                if (grant_hit_s && (grant_idx_s == 3'(c))) begin
                    grant_s[c]  = 1'b1;
                    grant_rad_s = bus.req_radicand[c*W +: W];
                end else begin
                    grant_s[c]  = 1'b0;
                end
            end
        end else begin
            grant_hit_s = 1'b0;
        end
    end

    // One restoring sqrt step: bring down two radicand bits, try subtracting 4*root+1.
    always_comb begin
        trial_s = (rem_r << 2) | RW'(x_r[W-1:W-2]);
        cmp_s   = {root_r, 2'b01};
        if (trial_s >= cmp_s) begin
            rem_next_s  = trial_s - cmp_s;
            root_next_s = (root_r << 1) | HW'(1);
        end else begin
            rem_next_s  = trial_s;
            root_next_s = root_r << 1;
        end
    end

    // Control FSM with datapath and held response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            ptr_r        <= 3'd0;
            cnt_r        <= '0;
            x_r          <= '0;
            rem_r        <= '0;
            root_r       <= '0;
            resp_valid_r <= 1'b0;
            resp_ch_r    <= 3'd0;
            resp_root_r  <= '0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_hit_s) begin
                        x_r       <= grant_rad_s;
                        rem_r     <= '0;
                        root_r    <= '0;
                        cnt_r     <= '0;
                        resp_ch_r <= grant_idx_s;
                        ptr_r     <= wrap_idx(grant_idx_s, 3'd1);
                        busy_r    <= 1'b1;
                        state_r   <= ITER;
                    end
                end
                ITER: begin
                    x_r    <= x_r << 2;
                    rem_r  <= rem_next_s;
                    root_r <= root_next_s;
                    if (cnt_r == LAST_CNT) begin
                        resp_root_r  <= W'(root_next_s);
                        resp_valid_r <= 1'b1;
                        state_r      <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = grant_s;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_ch    = resp_ch_r;
    assign bus.resp_root  = resp_root_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_rms_sqrt_scheduler.sv
// Randomized self-checking bench for rms_sqrt_scheduler: a reference of
// floor(sqrt) and round-robin arbitration drives the expectations.
module tb_rms_sqrt_scheduler;
    localparam int NCH = 4;
    localparam int W   = 16;
    localparam int HW  = W / 2;

    typedef logic [1:0] ch_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic [W-1:0] rad_drv [NCH];
    int   rad_m [NCH];
    ch_t  ptr_m;
    int   n_checks = 0;
    int   n_errors = 0;

    rms_sqrt_scheduler_if #(.NCH(NCH), .W(W)) bus ();

    rms_sqrt_scheduler #(.NCH(NCH), .W(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Pack the per-channel radicands onto the flat bus.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            bus.req_radicand[c*W +: W] = rad_drv[c];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int isqrt(input int v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic logic [NCH-1:0] exp_grant(input logic [NCH-1:0] v, input ch_t p);
        for (int i = 0; i < NCH; i++) begin
            ch_t c;
            c = ch_t'((int'(p) + i) % NCH);
            if (v[c]) return NCH'(1) << c;
        end
        return '0;
    endfunction

    task automatic set_req(input ch_t ch, input int rad);
        bus.req_valid[ch] = 1'b1;
        rad_drv[ch]       = W'(rad);
        rad_m[ch]         = rad;
    endtask

    task automatic grant_check(output ch_t g, output bit ok);
        logic [NCH-1:0] e;
        e = exp_grant(bus.req_valid, ptr_m);
        check_val("grant", 32'(bus.req_ready), 32'(e));
        ok = (e != '0);
        g  = 2'd0;
        for (int i = 0; i < NCH; i++) if (e[i]) g = ch_t'(i);
        if (ok) ptr_m = ch_t'(int'(g) + 1);
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic complete(input ch_t g, input logic [W-1:0] new_rad);
        int lat;
        @(posedge clk); #1;
        bus.req_valid[g] = 1'b0;
        rad_drv[g]       = new_rad;
        wait_resp(lat);
        check_val("latency", 32'(lat), 32'(HW + 1));
        check_val("resp_ch", 32'(bus.resp_ch), 32'(g));
        check_val("resp_root", 32'(bus.resp_root), 32'(isqrt(rad_m[g])));
        check_val("busy_done", 32'(busy), 32'd1);
    endtask

    task automatic run_one(input ch_t ch, input int rad);
        ch_t g;
        bit  ok;
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        set_req(ch, rad);
        @(negedge clk);
        check_val("busy_idle", 32'(busy), 32'd0);
        grant_check(g, ok);
        if (ok) begin
            complete(g, W'($urandom));
            @(negedge clk);
            check_val("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
        end
    endtask

    task automatic serve_all();
        ch_t g;
        bit  ok;
        @(negedge clk);
        for (int n = 0; n < NCH; n++) begin
            if (bus.req_valid == '0) break;
            grant_check(g, ok);
            if (!ok) break;
            complete(g, W'($urandom));
            @(negedge clk);
            check_val("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
        end
    endtask

    initial begin
        int  sweep [6];
        int  seen;
        ch_t g;
        bit  ok;
        sweep = '{0, 1, 99, 100, 16'h4000, 65535};

        // Reset with every channel already requesting.
        rst = 1'b1;
        bus.resp_ready = 1'b1;
        bus.req_valid  = '0;
        for (int c = 0; c < NCH; c++) rad_drv[c] = '0;
        set_req(2'd0, 4);
        set_req(2'd1, 9);
        set_req(2'd2, 16);
        set_req(2'd3, 25);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check_val("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check_val("rst_resp_ch", 32'(bus.resp_ch), 32'd0);
        check_val("rst_resp_root", 32'(bus.resp_root), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst   = 1'b0;
        ptr_m = 2'd0;

        // Round-robin over all four, then ch1 and ch3 again with ptr back at 0.
        serve_all();
        @(posedge clk); #1;
        set_req(2'd1, 121);
        set_req(2'd3, 169);
        serve_all();

        // Single maximum radicand on ch0.
        run_one(2'd0, 16'hFFFF);

        // Value sweep on ch2.
        foreach (sweep[i]) run_one(2'd2, sweep[i]);

        // Backpressure: ch1 result held while ch0 waits.
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        set_req(2'd1, 49);
        @(negedge clk);
        grant_check(g, ok);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        set_req(2'd0, 36);
        wait_resp(seen);
        check_val("bp_latency", 32'(seen), 32'(HW + 1));
        for (int i = 0; i < 6; i++) begin
            check_val("bp_valid", 32'(bus.resp_valid), 32'd1);
            check_val("bp_ch", 32'(bus.resp_ch), 32'd1);
            check_val("bp_root", 32'(bus.resp_root), 32'(isqrt(49)));
            check_val("bp_req_ready", 32'(bus.req_ready), 32'd0);
            if (i < 5) @(negedge clk);
        end
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check_val("bp_hs_valid", 32'(bus.resp_valid), 32'd1);
        check_val("bp_hs_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check_val("bp_after_valid", 32'(bus.resp_valid), 32'd0);
        grant_check(g, ok);
        if (ok) begin
            complete(g, W'($urandom));
            @(negedge clk);
            check_val("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
        end

        // Reset pulse in the middle of an iteration on ch3.
        @(posedge clk); #1;
        set_req(2'd3, 16'h0400);
        @(negedge clk);
        grant_check(g, ok);
        @(posedge clk); #1;
        bus.req_valid[3] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        ptr_m = 2'd0;
        seen  = 0;
        @(negedge clk);
        check_val("busy_after_rst", 32'(busy), 32'd0);
        for (int i = 0; i < 15; i++) begin
            if (bus.resp_valid) seen++;
            @(negedge clk);
        end
        check_val("rst_no_resp", 32'(seen), 32'd0);
        run_one(2'd3, 16'h0400);

        // Radicand changes right after grant; the sampled value must be used.
        @(posedge clk); #1;
        set_req(2'd0, 144);
        @(negedge clk);
        grant_check(g, ok);
        if (ok) begin
            complete(g, 16'd0);
            @(negedge clk);
            check_val("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
        end

        // Random channels and radicands against the floor(sqrt) reference.
        for (int i = 0; i < 1000; i++) begin
            run_one(ch_t'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 65535)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
